// File: rtl/sprite_pkg.sv
// Shared constants and FSM state type for the player sprite fetch pipeline.
package sprite_pkg;

  localparam int unsigned SPRITE_ADDR_W   = 18;
  localparam logic [7:0]  TRANSPARENT_IDX = 8'h00;
  localparam int unsigned FETCH_LATENCY   = 3;

  typedef enum logic {
    StIdle,
    StActive
  } fetch_state_e;

  // Per-frame copy of the sprite placement; facingLeft is kept separately.
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [31:0] offset;
  } sprite_shadow_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational hit test and sprite ROM address arithmetic for one raster pixel.
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic [9:0]               i_draw_x,
  input  logic [9:0]               i_draw_y,
  input  logic [9:0]               i_sx,
  input  logic [9:0]               i_sy,
  input  logic [9:0]               i_sw,
  input  logic [9:0]               i_sh,
  input  logic [31:0]              i_offset,
  input  logic                     i_mirror,
  output logic                     o_hit,
  output logic [SPRITE_ADDR_W-1:0] o_addr
);

  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit_x;
  logic        w_hit_y;
  logic [9:0]  w_col;
  logic [9:0]  w_row;
  logic [9:0]  w_col_m;
  logic [19:0] w_row_base;
  logic [31:0] w_sum;
  logic        w_unused_sum;

  // 11-bit end coordinates so a sprite straddling 1023 does not wrap to 0.
  assign w_x_end = {1'b0, i_sx} + {1'b0, i_sw};
  assign w_y_end = {1'b0, i_sy} + {1'b0, i_sh};

  assign w_hit_x = (i_draw_x >= i_sx) && ({1'b0, i_draw_x} < w_x_end);
  assign w_hit_y = (i_draw_y >= i_sy) && ({1'b0, i_draw_y} < w_y_end);
  assign o_hit   = w_hit_x && w_hit_y && (i_sw != 10'd0) && (i_sh != 10'd0);

  assign w_col      = i_draw_x - i_sx;
  assign w_row      = i_draw_y - i_sy;
  assign w_col_m    = i_mirror ? (i_sw - 10'd1 - w_col) : w_col;
  assign w_row_base = {10'd0, w_row} * {10'd0, i_sw};

  assign w_sum        = i_offset + {12'd0, w_row_base} + {22'd0, w_col_m};
  assign o_addr       = w_sum[SPRITE_ADDR_W-1:0];
  assign w_unused_sum = ^w_sum[31:SPRITE_ADDR_W];

endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: shadowed placement, 3-stage ROM fetch pipeline, IDLE/ACTIVE FSM.
// Build option: SPRITE_MIRROR_EN enables horizontal mirroring driven by facingLeft.
module player_sprite_fetch
  import sprite_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [9:0]               playerX,
  input  logic [9:0]               playerY,
  input  logic [9:0]               playerWidth,
  input  logic [9:0]               playerHeight,
  input  logic [31:0]              animationOffset,
  input  logic                     facingLeft,
  output logic [SPRITE_ADDR_W-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic                     pix_out_valid,
  output logic                     is_player,
  output logic [7:0]               color_idx
);

  fetch_state_e              r_state;
  fetch_state_e              w_state_next;
  sprite_shadow_t            r_shadow;
  logic                      w_mirror;
  logic                      w_hit;
  logic [SPRITE_ADDR_W-1:0]  w_addr;
  logic                      r_s1_valid;
  logic                      r_s1_hit;
  logic                      r_s2_valid;
  logic                      r_s2_hit;
  logic                      w_opaque;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (frame_start) w_state_next = StActive;
      StActive: w_state_next = StActive;
      default:  w_state_next = StIdle;
    endcase
  end

  // A pixel arriving with frame_start sees the old shadows: both read r_shadow this cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shadow <= '0;
    end else if (frame_start) begin
      r_shadow.x      <= playerX;
      r_shadow.y      <= playerY;
      r_shadow.w      <= playerWidth;
      r_shadow.h      <= playerHeight;
      r_shadow.offset <= animationOffset;
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic r_facing_left;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_facing_left <= 1'b0;
    end else if (frame_start) begin
      r_facing_left <= facingLeft;
    end
  end

  assign w_mirror = r_facing_left;
`else
  logic w_unused_facing;

  assign w_unused_facing = facingLeft;
  assign w_mirror        = 1'b0;
`endif

  sprite_addr_gen u_addr_gen (
    .i_draw_x (DrawX),
    .i_draw_y (DrawY),
    .i_sx     (r_shadow.x),
    .i_sy     (r_shadow.y),
    .i_sw     (r_shadow.w),
    .i_sh     (r_shadow.h),
    .i_offset (r_shadow.offset),
    .i_mirror (w_mirror),
    .o_hit    (w_hit),
    .o_addr   (w_addr)
  );

  // rom_data for the stage-2 pixel is on the bus now, one cycle behind rom_addr.
  assign w_opaque = r_s2_valid && r_s2_hit && (r_state == StActive) &&
                    (rom_data != TRANSPARENT_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr      <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_hit      <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_hit      <= 1'b0;
      pix_out_valid <= 1'b0;
      is_player     <= 1'b0;
      color_idx     <= 8'h00;
    end else begin
      if (pix_valid) begin
        rom_addr <= w_addr;
      end
      r_s1_valid    <= pix_valid;
      r_s1_hit      <= pix_valid && w_hit;
      r_s2_valid    <= r_s1_valid;
      r_s2_hit      <= r_s1_hit;
      pix_out_valid <= r_s2_valid;
      is_player     <= w_opaque;
      color_idx     <= w_opaque ? rom_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Self-checking bench for player_sprite_fetch: directed scenarios plus a randomized
// run against a plain-arithmetic sprite model with a synchronous ROM behind rom_addr.
module tb_player_sprite_fetch;

  localparam int N_RAND = 300;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  playerX = '0;
  logic [9:0]  playerY = '0;
  logic [9:0]  playerWidth = '0;
  logic [9:0]  playerHeight = '0;
  logic [31:0] animationOffset = '0;
  logic        facingLeft = 1'b0;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        pix_out_valid;
  logic        is_player;
  logic [7:0]  color_idx;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mem [0:262143];

  // Model sprite state as latched at the last frame_start.
  int     m_x, m_y, m_w, m_h;
  longint m_off;
  bit     m_face;

  player_sprite_fetch dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_start     (frame_start),
    .pix_valid       (pix_valid),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .playerX         (playerX),
    .playerY         (playerY),
    .playerWidth     (playerWidth),
    .playerHeight    (playerHeight),
    .animationOffset (animationOffset),
    .facingLeft      (facingLeft),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .pix_out_valid   (pix_out_valid),
    .is_player       (is_player),
    .color_idx       (color_idx)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: data for an address appears one cycle after it.
  always @(posedge Clk) rom_data <= mem[rom_addr];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic bit m_hit(input int dx, input int dy);
    return (m_w != 0) && (m_h != 0) && (dx >= m_x) && (dx < m_x + m_w) &&
           (dy >= m_y) && (dy < m_y + m_h);
  endfunction

  function automatic logic [17:0] m_addr(input int dx, input int dy);
    longint col, row, a;
    col = longint'(dx - m_x);
    row = longint'(dy - m_y);
`ifdef SPRITE_MIRROR_EN
    if (m_face) col = longint'(m_w) - 1 - col;
`endif
    a = m_off + row * longint'(m_w) + col;
    return a[17:0];
  endfunction

  task automatic model_clear;
    m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_off = 0; m_face = 0;
  endtask

  task automatic load_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] w,
                            input logic [9:0] h, input logic [31:0] off, input bit face);
    playerX = x; playerY = y; playerWidth = w; playerHeight = h;
    animationOffset = off; facingLeft = face;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    m_x = int'(x); m_y = int'(y); m_w = int'(w); m_h = int'(h);
    m_off = longint'(off); m_face = face;
  endtask

  // Sends one isolated pixel and captures the outputs at T+1 and T+3.
  task automatic apply_pixel(input logic [9:0] dx, input logic [9:0] dy,
                             output logic [17:0] a1, output logic early,
                             output logic v3, output logic p3, output logic [7:0] c3);
    DrawX = dx; DrawY = dy; pix_valid = 1'b1;
    tick;
    a1 = rom_addr;
    early = pix_out_valid;
    pix_valid = 1'b0;
    tick;
    early = early | pix_out_valid;
    tick;
    v3 = pix_out_valid; p3 = is_player; c3 = color_idx;
    tick;
  endtask

  task automatic test_reset;
    Reset = 1'b1; pix_valid = 1'b1; DrawX = 10'd5; DrawY = 10'd5;
    tick; tick;
    Reset = 1'b0; pix_valid = 1'b0;
    model_clear();
    n_checks++; if (rom_addr !== 18'd0) begin n_fail++;
      $display("FAIL reset_rom_addr got %0h want 0", rom_addr); end
    n_checks++; if (pix_out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_pix_out_valid got %b want 0", pix_out_valid); end
    n_checks++; if (is_player !== 1'b0) begin n_fail++;
      $display("FAIL reset_is_player got %b want 0", is_player); end
    n_checks++; if (color_idx !== 8'h00) begin n_fail++;
      $display("FAIL reset_color_idx got %0h want 0", color_idx); end
    tick; tick; tick;
    n_checks++; if (pix_out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_flush got %b want 0", pix_out_valid); end
  endtask

  task automatic test_idle_pixel;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    apply_pixel(10'd100, 10'd100, a1, early, v3, p3, c3);
    n_checks++; if (early !== 1'b0) begin n_fail++;
      $display("FAIL idle_early_valid got %b want 0", early); end
    n_checks++; if (v3 !== 1'b1) begin n_fail++;
      $display("FAIL idle_valid_t3 got %b want 1", v3); end
    n_checks++; if (p3 !== 1'b0 || c3 !== 8'h00) begin n_fail++;
      $display("FAIL idle_output got is_player=%b color=%0h want 0/0", p3, c3); end
  endtask

  task automatic test_hit;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    load_frame(10'd100, 10'd50, 10'd32, 10'd34, 32'd3264, 1'b0);
    mem[3333] = 8'h1A;
    apply_pixel(10'd105, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'd3333) begin n_fail++;
      $display("FAIL hit_rom_addr got %0d want 3333", a1); end
    n_checks++; if (v3 !== 1'b1 || early !== 1'b0) begin n_fail++;
      $display("FAIL hit_latency got v3=%b early=%b want 1/0", v3, early); end
    n_checks++; if (p3 !== 1'b1 || c3 !== 8'h1A) begin n_fail++;
      $display("FAIL hit_output got is_player=%b color=%0h want 1/1a", p3, c3); end
  endtask

  task automatic test_transparent_miss;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    mem[3333] = 8'h00;
    mem[3327] = 8'h66;
    mem[3359] = 8'h21;
    mem[3360] = 8'h55;
    apply_pixel(10'd105, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (v3 !== 1'b1 || p3 !== 1'b0 || c3 !== 8'h00) begin n_fail++;
      $display("FAIL transparent got v=%b is_player=%b color=%0h want 1/0/0", v3, p3, c3); end
    apply_pixel(10'd132, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (p3 !== 1'b0 || c3 !== 8'h00) begin n_fail++;
      $display("FAIL miss_right got is_player=%b color=%0h want 0/0", p3, c3); end
    apply_pixel(10'd99, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (p3 !== 1'b0 || c3 !== 8'h00) begin n_fail++;
      $display("FAIL miss_left got is_player=%b color=%0h want 0/0", p3, c3); end
    apply_pixel(10'd131, 10'd83, a1, early, v3, p3, c3);
    mem[3264 + 33*32 + 31] = mem[3264 + 33*32 + 31];
    n_checks++; if (a1 !== 18'd4351 || p3 !== 1'b1 ||
                    c3 !== mem[4351]) begin n_fail++;
      $display("FAIL last_pixel got addr=%0d is_player=%b color=%0h want 4351/1/%0h",
               a1, p3, c3, mem[4351]); end
    apply_pixel(10'd131, 10'd84, a1, early, v3, p3, c3);
    n_checks++; if (p3 !== 1'b0) begin n_fail++;
      $display("FAIL miss_below got is_player=%b want 0", p3); end
  endtask

  task automatic test_mirror;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    logic [17:0] exp_a;
    load_frame(10'd100, 10'd50, 10'd32, 10'd34, 32'd3264, 1'b1);
    mem[3333] = 8'h1A;
    mem[3354] = 8'h2B;
`ifdef SPRITE_MIRROR_EN
    exp_a = 18'd3354;
`else
    exp_a = 18'd3333;
`endif
    apply_pixel(10'd105, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== exp_a) begin n_fail++;
      $display("FAIL mirror_rom_addr got %0d want %0d", a1, exp_a); end
    n_checks++; if (p3 !== 1'b1 || c3 !== mem[exp_a]) begin n_fail++;
      $display("FAIL mirror_output got is_player=%b color=%0h want 1/%0h", p3, c3, mem[exp_a]); end
  endtask

  task automatic test_wrap;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    load_frame(10'd1000, 10'd50, 10'd32, 10'd34, 32'd3264, 1'b0);
    mem[3338] = 8'h77;
    mem[3351] = 8'h44;
    apply_pixel(10'd5, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (v3 !== 1'b1 || p3 !== 1'b0) begin n_fail++;
      $display("FAIL nowrap_miss got v=%b is_player=%b want 1/0", v3, p3); end
    apply_pixel(10'd1010, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'd3338 || p3 !== 1'b1 || c3 !== 8'h77) begin n_fail++;
      $display("FAIL edge_hit got addr=%0d is_player=%b color=%0h want 3338/1/77", a1, p3, c3); end
    apply_pixel(10'd1023, 10'd52, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'd3351 || p3 !== 1'b1 || c3 !== 8'h44) begin n_fail++;
      $display("FAIL x1023_hit got addr=%0d is_player=%b color=%0h want 3351/1/44", a1, p3, c3); end
    load_frame(10'd100, 10'd50, 10'd32, 10'd34, 32'h3FFFF, 1'b0);
    mem[18'h3FFFF] = 8'h3C;
    apply_pixel(10'd100, 10'd50, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'h3FFFF || c3 !== 8'h3C) begin n_fail++;
      $display("FAIL offset_max got addr=%0h color=%0h want 3ffff/3c", a1, c3); end
    apply_pixel(10'd101, 10'd50, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'h00000) begin n_fail++;
      $display("FAIL addr_wrap got %0h want 0", a1); end
  endtask

  task automatic test_hold;
    logic [17:0] a1; logic early, v3, p3; logic [7:0] c3;
    playerX = 10'd7; playerY = 10'd9; playerWidth = 10'd3; playerHeight = 10'd3;
    animationOffset = 32'h12345; facingLeft = 1'b1;
    apply_pixel(10'd100, 10'd50, a1, early, v3, p3, c3);
    n_checks++; if (a1 !== 18'h3FFFF || p3 !== 1'b1 || c3 !== 8'h3C) begin n_fail++;
      $display("FAIL hold_shadow got addr=%0h is_player=%b color=%0h want 3ffff/1/3c",
               a1, p3, c3); end
    tick; tick;
    n_checks++; if (rom_addr !== 18'h3FFFF) begin n_fail++;
      $display("FAIL hold_idle_addr got %0h want 3ffff", rom_addr); end
  endtask

  task automatic test_back_to_back_reset;
    load_frame(10'd100, 10'd50, 10'd32, 10'd34, 32'd3264, 1'b0);
    for (int i = 0; i < 14; i++) mem[3264 + 64 + i] = 8'hA0 + 8'(i);
    for (int c = 0; c < 14; c++) begin
      pix_valid = (c < 10);
      Reset = (c == 3);
      DrawX = 10'(100 + c); DrawY = 10'd52;
      tick;
      if (c == 3) model_clear();
      // Now observing cycle c+1.
      if (c + 1 >= 4) begin
        n_checks++;
        if (pix_out_valid !== ((c + 1 - 3 >= 4) && (c + 1 - 3 <= 9))) begin n_fail++;
          $display("FAIL b2b_valid cycle %0d got %b want %b", c + 1, pix_out_valid,
                   ((c + 1 - 3 >= 4) && (c + 1 - 3 <= 9))); end
        n_checks++;
        if (is_player !== 1'b0 || color_idx !== 8'h00) begin n_fail++;
          $display("FAIL b2b_post_reset cycle %0d got is_player=%b color=%0h want 0/0",
                   c + 1, is_player, color_idx); end
      end
      if (c + 1 == 4) begin
        n_checks++;
        if (rom_addr !== 18'd0) begin n_fail++;
          $display("FAIL b2b_reset_addr got %0h want 0", rom_addr); end
      end
    end
    pix_valid = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_random;
    bit         ev [0:N_RAND+4];
    bit         ep [0:N_RAND+4];
    logic [7:0] ec [0:N_RAND+4];
    bit         pv, fs, h, chk_addr;
    logic [17:0] a, exp_a;
    for (int i = 0; i <= N_RAND + 4; i++) begin ev[i] = 0; ep[i] = 0; ec[i] = 8'h00; end
    Reset = 1'b1; tick; Reset = 1'b0; model_clear();
    exp_a = '0;
    for (int c = 0; c < N_RAND + 3; c++) begin
      pv = (c < N_RAND) && ($urandom_range(0, 3) != 0);
      fs = (c < N_RAND) && ($urandom_range(0, 24) == 0);
      playerX = 10'($urandom_range(0, 1023));
      playerY = 10'($urandom_range(0, 1023));
      playerWidth = 10'($urandom_range(0, 40));
      playerHeight = 10'($urandom_range(0, 40));
      animationOffset = $urandom;
      facingLeft = 1'($urandom_range(0, 1));
      DrawX = 10'(m_x + $urandom_range(0, 48) - 4);
      DrawY = 10'(m_y + $urandom_range(0, 48) - 4);
      chk_addr = 0;
      if (pv) begin
        h = m_hit(int'(DrawX), int'(DrawY));
        a = m_addr(int'(DrawX), int'(DrawY));
        ev[c+3] = 1;
        // A hit implies a frame_start has already occurred, so the FSM is ACTIVE.
        ep[c+3] = h && (mem[a] != 8'h00);
        ec[c+3] = ep[c+3] ? mem[a] : 8'h00;
        chk_addr = h;
        exp_a = a;
      end
      if (fs) begin
        m_x = int'(playerX); m_y = int'(playerY); m_w = int'(playerWidth);
        m_h = int'(playerHeight); m_off = longint'(animationOffset); m_face = facingLeft;
      end
      pix_valid = pv; frame_start = fs;
      tick;
      if (chk_addr) begin
        n_checks++;
        if (rom_addr !== exp_a) begin n_fail++;
          $display("FAIL rand_rom_addr cycle %0d got %0h want %0h", c + 1, rom_addr, exp_a); end
      end
      n_checks++;
      if (pix_out_valid !== ev[c+1]) begin n_fail++;
        $display("FAIL rand_valid cycle %0d got %b want %b", c + 1, pix_out_valid, ev[c+1]); end
      if (ev[c+1]) begin
        n_checks++;
        if (is_player !== ep[c+1] || color_idx !== ec[c+1]) begin n_fail++;
          $display("FAIL rand_pixel cycle %0d got is_player=%b color=%0h want %b/%0h",
                   c + 1, is_player, color_idx, ep[c+1], ec[c+1]); end
      end
    end
    pix_valid = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    model_clear();
    test_reset();
    test_idle_pixel();
    test_hit();
    test_transparent_miss();
    test_mirror();
    test_wrap();
    test_hold();
    test_back_to_back_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
